mux_scan_argmax: RTL and testbench

Scan controller placed around the registered `MUX_base` word selector: drives its `sel` and consumes its `out`. On a start command it walks a contiguous range of mux entries, wrapping past the top index, and returns the largest word and the index where it was found. The block hides the mux's one-cycle output latency and replaces software polling of 512 entries with one handshake.

---
 rtl/mux_scan_argmax_pkg.sv | 10 +
 rtl/mux_scan_argmax_if.sv | 21 ++
 rtl/MUX_base.sv | 23 ++
 rtl/mux_scan_argmax.sv | 131 +++++++++++++
 tb/tb_mux_scan_argmax.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_argmax_pkg.sv
// Shared types for the mux scan/argmax controller.
package mux_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } scan_state_e;

endpackage

// File: rtl/mux_scan_argmax_if.sv
// Request/result bus between a host and the mux scan/argmax controller.
interface mux_scan_argmax_if #(
   parameter int BIT          = 27,
   parameter int NUMBER_INPUT = 512
);
   localparam int IDXW = $clog2(NUMBER_INPUT);

   logic            start;
   logic [IDXW-1:0] base;
   logic [IDXW:0]   len;
   logic            busy;
   logic            done;
   logic            err;
   logic [BIT-1:0]  max_val;
   logic [IDXW-1:0] max_idx;

   modport master (output start, base, len,
                   input  busy, done, err, max_val, max_idx);
   modport slave  (input  start, base, len,
                   output busy, done, err, max_val, max_idx);
endinterface

// File: rtl/MUX_base.sv
// Registered word selector: out follows IN[sel] one clock later.
module MUX_base #(
   parameter int BIT          = 27,
   parameter int NUMBER_INPUT = 512,
   localparam int IDXW        = $clog2(NUMBER_INPUT)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [IDXW-1:0]                    sel,
   input  logic [NUMBER_INPUT-1:0][BIT-1:0]   IN,
   output logic [BIT-1:0]                     out
);

   // Output register of the selected word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= {BIT{1'b0}};
      end else begin
         out <= IN[sel];
      end
   end

endmodule

// File: rtl/mux_scan_argmax.sv
// Walks a wrapping index range through MUX_base and reports the largest word
// and where it was first seen in scan order.
module mux_scan_argmax
   import mux_scan_pkg::*;
#(
   parameter int BIT          = 27,
   parameter int NUMBER_INPUT = 512,
   localparam int IDXW        = $clog2(NUMBER_INPUT)
) (
   input  logic             clk,
   input  logic             rst_n,
   mux_scan_argmax_if.slave bus,
   output logic [IDXW-1:0]  o_sel,
   input  logic [BIT-1:0]   i_mux_out
);

   scan_state_e     r_state;
   logic [IDXW-1:0] r_sel;
   logic [IDXW:0]   r_len;
   logic [IDXW:0]   r_cnt;
   logic            r_pv;
   logic [IDXW-1:0] r_pidx;
   logic            r_seen;
   logic [BIT-1:0]  r_run_val;
   logic [IDXW-1:0] r_run_idx;
   logic            r_busy;
   logic            r_done;
   logic            r_err;
   logic [BIT-1:0]  r_max_val;
   logic [IDXW-1:0] r_max_idx;

   logic            w_len_ok;
   logic [IDXW-1:0] w_sel_inc;
   logic            w_take;
   logic [BIT-1:0]  w_nxt_val;
   logic [IDXW-1:0] w_nxt_idx;

   // Request check, wrapping index increment and running-max update
   always_comb begin
      w_len_ok = (bus.len != {(IDXW+1){1'b0}}) &&
                 (bus.len <= (IDXW+1)'(NUMBER_INPUT));
      if (r_sel == IDXW'(NUMBER_INPUT - 1)) begin
         w_sel_inc = {IDXW{1'b0}};
      end else begin
         w_sel_inc = r_sel + IDXW'(1);
      end
      // Strict compare keeps the earliest entry in scan order on ties
      w_take = r_pv && (!r_seen || (i_mux_out > r_run_val));
      if (w_take) begin
         w_nxt_val = i_mux_out;
         w_nxt_idx = r_pidx;
      end else begin
         w_nxt_val = r_run_val;
         w_nxt_idx = r_run_idx;
      end
   end

   // Scan FSM, sample delay pipe and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_sel     <= {IDXW{1'b0}};
         r_len     <= {(IDXW+1){1'b0}};
         r_cnt     <= {(IDXW+1){1'b0}};
         r_pv      <= 1'b0;
         r_pidx    <= {IDXW{1'b0}};
         r_seen    <= 1'b0;
         r_run_val <= {BIT{1'b0}};
         r_run_idx <= {IDXW{1'b0}};
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_max_val <= {BIT{1'b0}};
         r_max_idx <= {IDXW{1'b0}};
      end else begin
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_pv      <= (r_state == ST_SCAN);
         r_pidx    <= r_sel;
         r_run_val <= w_nxt_val;
         r_run_idx <= w_nxt_idx;
         if (w_take) begin
            r_seen <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  if (w_len_ok) begin
                     r_len   <= bus.len;
                     r_sel   <= bus.base;
                     r_cnt   <= (IDXW+1)'(1);
                     r_seen  <= 1'b0;
                     r_busy  <= 1'b1;
                     r_state <= ST_SCAN;
                  end else begin
                     r_done <= 1'b1;
                     r_err  <= 1'b1;
                  end
               end
            end
            ST_SCAN: begin
               if (r_cnt == r_len) begin
                  r_state <= ST_DRAIN;
               end else begin
                  r_sel <= w_sel_inc;
                  r_cnt <= r_cnt + (IDXW+1)'(1);
               end
            end
            ST_DRAIN: begin
               r_state   <= ST_IDLE;
               r_busy    <= 1'b0;
               r_done    <= 1'b1;
               r_max_val <= w_nxt_val;
               r_max_idx <= w_nxt_idx;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_sel       = r_sel;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.err     = r_err;
   assign bus.max_val = r_max_val;
   assign bus.max_idx = r_max_idx;

endmodule

// File: tb/tb_mux_scan_argmax.sv
// Directed bench for mux_scan_argmax driving a MUX_base with a bench-owned word table.
module tb_mux_scan_argmax;

   localparam int BIT = 27;
   localparam int N   = 512;

   typedef struct {
      logic [8:0]  base;
      logic [9:0]  len;
      logic        ov1_en;
      logic [8:0]  ov1_idx;
      logic [26:0] ov1_val;
      logic        ov2_en;
      logic [8:0]  ov2_idx;
      logic [26:0] ov2_val;
      logic        exp_err;
      logic [26:0] exp_val;
      logic [8:0]  exp_idx;
   } vec_t;

   logic                     clk;
   logic                     rst_n;
   logic [8:0]               sel;
   logic [BIT-1:0]           mux_out;
   logic [N-1:0][BIT-1:0]    mux_in;

   int          n_chk;
   int          n_fail;
   logic [26:0] last_val;
   logic [8:0]  last_idx;
   logic [8:0]  exp_sel;
   vec_t        vecs [9];

   mux_scan_argmax_if #(.BIT(BIT), .NUMBER_INPUT(N)) bus ();

   mux_scan_argmax #(.BIT(BIT), .NUMBER_INPUT(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .o_sel     (sel),
      .i_mux_out (mux_out)
   );

   MUX_base #(.BIT(BIT), .NUMBER_INPUT(N)) u_mux (
      .clk   (clk),
      .rst_n (rst_n),
      .sel   (sel),
      .IN    (mux_in),
      .out   (mux_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fill_default();
      for (int i = 0; i < N; i++) mux_in[i] = 27'(i % 256);
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int cyc;
      bit got;
      longint exp_lat;
      fill_default();
      if (v.ov1_en) mux_in[v.ov1_idx] = v.ov1_val;
      if (v.ov2_en) mux_in[v.ov2_idx] = v.ov2_val;
      @(negedge clk);
      bus.start = 1'b1;
      bus.base  = v.base;
      bus.len   = v.len;
      @(posedge clk);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 1100) begin
         @(negedge clk);
         if (cyc == 0) begin
            bus.start = 1'b0;
            check($sformatf("v%0d busy_after_accept", id), bus.busy, v.exp_err ? 0 : 1);
         end
         if (!v.exp_err && cyc < int'(v.len))
            check($sformatf("v%0d sel_k%0d", id, cyc), sel, (int'(v.base) + cyc) % N);
         if (bus.done) got = 1'b1;
         else begin
            @(posedge clk);
            cyc++;
         end
      end
      if (!got) begin
         check($sformatf("v%0d done_timeout", id), 0, 1);
      end else begin
         exp_lat = v.exp_err ? 0 : longint'(v.len) + 1;
         check($sformatf("v%0d latency", id), cyc, exp_lat);
         check($sformatf("v%0d err", id), bus.err, v.exp_err);
         check($sformatf("v%0d busy_at_done", id), bus.busy, 0);
         if (v.exp_err) begin
            check($sformatf("v%0d max_val_held", id), bus.max_val, last_val);
            check($sformatf("v%0d max_idx_held", id), bus.max_idx, last_idx);
            check($sformatf("v%0d sel_held", id), sel, exp_sel);
         end else begin
            check($sformatf("v%0d max_val", id), bus.max_val, v.exp_val);
            check($sformatf("v%0d max_idx", id), bus.max_idx, v.exp_idx);
            last_val = v.exp_val;
            last_idx = v.exp_idx;
            exp_sel  = 9'((int'(v.base) + int'(v.len) - 1) % N);
         end
         @(negedge clk);
         check($sformatf("v%0d done_one_cycle", id), bus.done, 0);
      end
   endtask

   function automatic vec_t mk(input int base, input int len,
                               input int o1i, input int o1v, input int o2i, input int o2v,
                               input bit err, input int ev, input int ei);
      vec_t v;
      v.base    = 9'(base);
      v.len     = 10'(len);
      v.ov1_en  = (o1i >= 0);
      v.ov1_idx = 9'(o1i < 0 ? 0 : o1i);
      v.ov1_val = 27'(o1v);
      v.ov2_en  = (o2i >= 0);
      v.ov2_idx = 9'(o2i < 0 ? 0 : o2i);
      v.ov2_val = 27'(o2v);
      v.exp_err = err;
      v.exp_val = 27'(ev);
      v.exp_idx = 9'(ei);
      return v;
   endfunction

   initial begin
      int cyc;
      int n_done;
      n_chk    = 0;
      n_fail   = 0;
      last_val = 27'd0;
      last_idx = 9'd0;
      exp_sel  = 9'd0;

      vecs[0] = mk(10,  5,   -1, 0,          -1, 0,   1'b0, 14,         14);
      vecs[1] = mk(510, 4,   511, 900,       -1, 0,   1'b0, 900,        511);
      vecs[2] = mk(508, 8,   509, 777,       2, 777,  1'b0, 777,        509);
      vecs[3] = mk(300, 512, 299, 27'h7FFFFFF, -1, 0, 1'b0, 27'h7FFFFFF, 299);
      vecs[4] = mk(256, 1,   -1, 0,          -1, 0,   1'b0, 0,          256);
      vecs[5] = mk(7,   1,   -1, 0,          -1, 0,   1'b0, 7,          7);
      vecs[6] = mk(0,   3,   0, 50,          1, 50,   1'b0, 50,         0);
      vecs[7] = mk(33,  0,   -1, 0,          -1, 0,   1'b1, 0,          0);
      vecs[8] = mk(44,  513, -1, 0,          -1, 0,   1'b1, 0,          0);

      bus.start = 1'b0;
      bus.base  = 9'd0;
      bus.len   = 10'd0;
      fill_default();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      check("rst sel",     sel,         0);
      check("rst busy",    bus.busy,    0);
      check("rst done",    bus.done,    0);
      check("rst err",     bus.err,     0);
      check("rst max_val", bus.max_val, 0);
      check("rst max_idx", bus.max_idx, 0);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // start pulsed mid-scan must be ignored and not queued
      fill_default();
      @(negedge clk);
      bus.start = 1'b1; bus.base = 9'd0; bus.len = 10'd4;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.base = 9'd100; bus.len = 10'd2;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 2;
      while (!bus.done && cyc < 50) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      check("busy_start latency", cyc, 5);
      check("busy_start max_val", bus.max_val, 3);
      check("busy_start max_idx", bus.max_idx, 3);
      n_done = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      check("busy_start no_second_done", n_done, 0);
      check("busy_start idle_busy", bus.busy, 0);

      // reset in the middle of a scan
      @(negedge clk);
      bus.start = 1'b1; bus.base = 9'd0; bus.len = 10'd20;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_rst busy", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst sel",     sel,         0);
      check("mid_rst busy",    bus.busy,    0);
      check("mid_rst done",    bus.done,    0);
      check("mid_rst err",     bus.err,     0);
      check("mid_rst max_val", bus.max_val, 0);
      check("mid_rst max_idx", bus.max_idx, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      check("post_rst no_done", n_done, 0);
      last_val = 27'd0;
      last_idx = 9'd0;
      exp_sel  = 9'd0;
      run_vec(mk(20, 3, -1, 0, -1, 0, 1'b0, 22, 22), 9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
